// File: rtl/neuron_accumulator.sv
// Purpose: accumulate N_INPUTS (pixel, weight) pairs plus a bias into one saturated neuron sum (RELU_EN: clamp negatives to 0).
// Latency: result valid in the cycle after the final pair handshake; one bubble cycle between samples.
// Backpressure: in_ready drops while a result waits for out_ready; pairs offered then are dropped and flagged sticky.
module neuron_accumulator #(
    parameter int                        N_INPUTS  = 784,
    parameter int                        W_WIDTH   = 8,
    parameter int                        OUT_WIDTH = 16,
    parameter logic signed [W_WIDTH-1:0] BIAS      = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_pixel,
    input  logic [W_WIDTH-1:0]   in_weight,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_count_err
);

    // Accumulator is wide enough for N_INPUTS weights plus the bias, so no intermediate overflow.
    localparam int ACC_W = W_WIDTH + $clog2(N_INPUTS) + 1;
    localparam int CNT_W = $clog2(N_INPUTS);

    localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] BIAS_EXT = {{(ACC_W-W_WIDTH){BIAS[W_WIDTH-1]}}, BIAS};
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum_total;
    logic [OUT_WIDTH-1:0]    out_word;
    logic                    accept;
    logic                    last_pair;

    // Handshake flags decode from registered state; reset forces in_ready low.
    assign in_ready  = (state == ACCUM) && !rst;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign last_pair = accept && (cnt == LAST_IDX);

    assign term      = in_pixel ? {{(ACC_W-W_WIDTH){in_weight[W_WIDTH-1]}}, in_weight} : '0;
    assign sum_total = acc + term + BIAS_EXT;

    // Clamp the final sum into the output range; optional ReLU on top.
    always_comb begin
        out_word = sum_total[OUT_WIDTH-1:0];
        if (sum_total > SAT_MAX) begin
            out_word = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (sum_total < SAT_MIN) begin
            out_word = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
`ifdef RELU_EN
        if (out_word[OUT_WIDTH-1]) begin
            out_word = '0;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave ACCUM on the final pair, leave HOLD on the output handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (last_pair) state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Running sum and pair counter; both restart once the final pair is folded in.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (last_pair) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc + term;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Result register: written only on the final pair so it stays stable through HOLD and after.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (last_pair) begin
            out_data <= out_word;
        end
    end

    // Sticky flag for pairs offered while the block cannot take them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count_err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            out_count_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
module tb_neuron_accumulator;

    localparam int N      = 4;
    localparam int WW     = 8;
    localparam int OW     = 8;
    localparam int BIAS_V = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_pixel;
    logic [WW-1:0] in_weight;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_count_err;

    int errors = 0;
    int checks = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    neuron_accumulator #(
        .N_INPUTS (N),
        .W_WIDTH  (WW),
        .OUT_WIDTH(OW),
        .BIAS     (8'sd3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pixel     (in_pixel),
        .in_weight    (in_weight),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count_err(out_count_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
        end
    endtask

    // Reference: plain sum of selected weights plus bias, clamped to the output range.
    function automatic int ref_neuron(input int pix[N], input int wt[N]);
        int s;
        s = BIAS_V;
        for (int i = 0; i < N; i++) begin
            if (pix[i] != 0) s += wt[i];
        end
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_err = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_count_err", out_count_err, 0);
        chk("rst_in_ready_after", in_ready, 1);
    endtask

    // One complete sample: pairs with optional gaps, optional output stall with illegal pulses.
    task automatic run_sample(input int pix[N], input int wt[N], input int gap, input int hold, input bit pulse);
        int e;
        logic [31:0] wv;
        e = ref_neuron(pix, wt);
        for (int i = 0; i < N; i++) begin
            chk("accum_in_ready", in_ready, 1);
            chk("accum_out_valid", out_valid, 0);
            wv        = wt[i];
            in_valid  = 1'b1;
            in_pixel  = (pix[i] != 0);
            in_weight = wv[WW-1:0];
            out_ready = (hold == 0);
            tick();
            in_valid  = 1'b0;
            in_pixel  = 1'($urandom);
            in_weight = WW'($urandom);
            if (i < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk("gap_in_ready", in_ready, 1);
                    chk("gap_out_valid", out_valid, 0);
                    tick();
                end
            end
        end
        chk("result_valid", out_valid, 1);
        chk("result_data", $signed(out_data), e);
        chk("result_in_ready", in_ready, 0);
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            if (pulse) begin
                in_valid  = 1'b1;
                in_pixel  = 1'b1;
                in_weight = WW'($urandom);
                exp_err   = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", $signed(out_data), e);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_data_kept", $signed(out_data), e);
        chk("count_err", out_count_err, exp_err);
    endtask

    initial begin
        int p[N];
        int w[N];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = 1'b0;
        in_weight = '0;
        out_ready = 1'b0;
        tick();
        do_reset();

        // Basic sum, then the same with gaps between pairs.
        p = '{1, 1, 0, 1};
        w = '{10, 20, 30, -5};
        run_sample(p, w, 0, 0, 1'b0);
        run_sample(p, w, 2, 0, 1'b0);

        // Back-to-back samples with out_ready held high.
        p = '{1, 1, 1, 1};
        w = '{1, 2, 3, 4};
        run_sample(p, w, 0, 0, 1'b0);
        w = '{-1, -2, -3, -4};
        run_sample(p, w, 0, 0, 1'b0);

        // Saturation both ways.
        w = '{127, 127, 127, 127};
        run_sample(p, w, 0, 0, 1'b0);
        w = '{-128, -128, -128, -128};
        run_sample(p, w, 0, 0, 1'b0);

        // Backpressure with dropped pulses; the next sample must be unaffected.
        p = '{1, 1, 0, 1};
        w = '{10, 20, 30, -5};
        run_sample(p, w, 0, 5, 1'b1);
        run_sample(p, w, 0, 0, 1'b0);

        // Reset mid-sample discards the partial sum.
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            in_pixel  = 1'b1;
            in_weight = 8'd50;
            tick();
        end
        in_valid = 1'b0;
        do_reset();
        p = '{1, 1, 1, 0};
        w = '{1, 1, 1, 9};
        run_sample(p, w, 0, 0, 1'b0);

        // Reset during HOLD, with in_valid and out_ready also high: reset wins.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid  = 1'b1;
            in_pixel  = 1'b1;
            in_weight = 8'd7;
            tick();
        end
        in_valid = 1'b0;
        chk("hold_before_rst", out_valid, 1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        do_reset();
        p = '{0, 1, 1, 0};
        w = '{100, -20, 5, 100};
        run_sample(p, w, 1, 0, 1'b0);

        // Randomized samples with extremes mixed in.
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < N; i++) begin
                p[i] = int'($urandom_range(0, 1));
                w[i] = int'($urandom_range(0, 255)) - 128;
                if (s % 8 == 0) begin
                    p[i] = 1;
                    w[i] = 127;
                end else if (s % 8 == 1) begin
                    p[i] = 1;
                    w[i] = -128;
                end
            end
            run_sample(p, w, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Sequential accumulate stage for one hidden/output neuron of the digit classifier. It consumes a stream of (binarized pixel, signed weight) pairs and adds the weight whenever the pixel is 1. After N_INPUTS pairs it adds a bias, saturates the sum, and presents it on a valid/ready output. It sits downstream of the pixel/weight fetch logic and upstream of the argmax/compare stage. Its adder datapath is built on the team's half/full adder cells.

## Interface
- N_INPUTS, default 784: number of pairs per sample, minimum 2.
- W_WIDTH, default 8: signed weight width.
- OUT_WIDTH, default 16: signed output width, with OUT_WIDTH ≤ ACC_W.
- BIAS, default 0: signed bias added once per sample, W_WIDTH bits.
- Derived ACC_W = W_WIDTH + $clog2(N_INPUTS) + 1: internal accumulator width. This width cannot overflow.

- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: the current pair is valid.
- in_ready, output, 1: the block can accept a pair.
- in_pixel, input, 1: binarized pixel.
- in_weight, input, W_WIDTH: signed weight.
- out_valid, output, 1: a result is available.
- out_ready, input, 1: the consumer accepts the result.
- out_data, output, OUT_WIDTH: signed, saturated neuron sum.
- out_count_err, output, 1: sticky flag, set if in_valid is asserted while in_ready is low.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - On an input handshake (in_valid & in_ready):
    - acc ← acc + (in_pixel ? sext(in_weight) : 0)
    - cnt ← cnt + 1
  - When a handshake occurs with cnt == N_INPUTS-1:
    - out_data ← sat(acc + term + sext(BIAS))
    - acc ← 0
    - cnt ← 0
    - state → HOLD
- HOLD:
  - in_ready=0, out_valid=1, and out_data is held stable.
  - On out_valid & out_ready: state → ACCUM.
- Saturation: values above 2^(OUT_WIDTH-1)-1 clamp to that maximum. Values below -2^(OUT_WIDTH-1) clamp to that minimum.
- in_valid without a handshake:
  - No state change.
  - In HOLD, the pair is dropped and out_count_err is set.
  - out_count_err clears only on rst.
- When in_valid is low, acc and cnt are unchanged. Gaps between pairs are legal.
- in_pixel and in_weight are sampled only on a handshake cycle.
- Reset values: state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, out_count_err=0.
- in_ready is 0 in any cycle where rst=1.
- Reset mid-sample discards the partial sum. Reset during HOLD discards the pending result.

## Timing
- Throughput: one pair per cycle in ACCUM.
- Result latency: the last pair handshake at edge t gives out_valid=1 and a valid out_data after edge t. It is visible in cycle t+1.
- Output handshake at edge t gives in_ready=1 in cycle t+1. There is one bubble cycle between samples.
- in_ready and out_valid decode from the registered state only. They have no combinational path from in_valid or out_ready.
- out_data is registered and changes only on the final-pair handshake or on rst.
- If rst and in_valid are both high at an edge, reset wins.
- If rst and out_ready are both high at an edge, reset wins.

## Configuration
- RELU_EN defined:
  - The value written to out_data is max(0, sat(...)).
  - Negative results appear as 0.
- RELU_EN undefined:
  - out_data is the signed saturated sum.
  - Negative values pass through.
- The macro affects only the out_data write path. Handshake, state and timing are identical in both builds.

## Test plan
All scenarios use N_INPUTS=4, W_WIDTH=8, OUT_WIDTH=8, and BIAS=3 unless noted.
- Basic sum:
  - Stimulus: pixels 1,1,0,1 with weights 10,20,30,-5 on consecutive cycles, out_ready=1.
  - Required: out_data=28 in the cycle after the 4th pair; out_valid high for 1 cycle; in_ready low for exactly that cycle.
- Saturation:
  - Stimulus: four pairs of pixel 1, weight 127, with BIAS=0.
  - Required: out_data=127.
  - Stimulus: four pairs of pixel 1, weight -128.
  - Required: out_data=-128 without RELU_EN, 0 with RELU_EN.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the result appears, while in_valid pulses high.
  - Required: out_valid stays 1; out_data stays constant; in_ready stays 0; out_count_err=1; the next sample is unaffected by the dropped pulses.
- Input gaps:
  - Stimulus: the basic-sum pairs, with in_valid low for 2 cycles between each pair.
  - Required: out_data=28, and out_valid is asserted exactly 1 cycle after the 4th handshake.
- Reset mid-sample:
  - Stimulus: 2 pairs (1,50), then rst for 1 cycle, then pairs (1,1),(1,1),(1,1),(0,9).
  - Required: out_data=6; out_count_err=0.
- Back-to-back samples:
  - Stimulus: out_ready held at 1, with two samples streamed continuously: first weights 1,2,3,4, then -1,-2,-3,-4, all pixels 1.
  - Required: out_data=13 then -7, with one bubble cycle between samples.
